// File: rtl/framebuffer_pkg.sv
// rtl/framebuffer_pkg.sv - CHIP-8 framebuffer geometry constants and FSM state encoding
package framebuffer_pkg;

  localparam int FB_W          = 64;
  localparam int FB_H          = 32;
  localparam int FB_BYTES      = 256;
  localparam int OLED_PAGES    = 8;
  localparam int ROWS_PER_PAGE = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_FETCH,
    ST_RD_LAST,
    ST_RD_ACK,
    ST_DW_RD0,
    ST_DW_WR0,
    ST_DW_RD1,
    ST_DW_WR1,
    ST_DONE,
    ST_CLR
  } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - 256x8 single-port RAM, synchronous read and write, no reset
module fb_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [0:255];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/framebuffer.sv
// rtl/framebuffer.sv - 64x32 CHIP-8 display memory: XOR sprite draw/clear on the write side,
// 2x-scaled OLED page bytes on the read side.
module framebuffer
  import framebuffer_pkg::*;
#(
  parameter int SCALE_SHIFT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       read,
  input  logic [5:0] row_idx,
  input  logic [6:0] column_idx,
  output logic [7:0] data,
  output logic       ack,
  input  logic       draw_req,
  input  logic       draw_clear,
  input  logic [5:0] draw_x,
  input  logic [4:0] draw_y,
  input  logic [7:0] draw_byte,
  output logic       draw_done,
  output logic       collision
);

  fb_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic [5:0] rd_row_q, rd_row_d;
  logic [6:0] rd_col_q, rd_col_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] addr0_q, addr0_d;
  logic [7:0] mask0_q, mask0_d;
  logic [7:0] mask1_q, mask1_d;
  logic       two_q, two_d;
  logic       coll_acc_q, coll_acc_d;
  logic [7:0] data_q, data_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       coll_q, coll_d;

  logic       ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic [6:0] pix_c_full;
  logic [5:0] pix_c;
  logic       pix;
  logic [5:0] sel_row;
  logic [1:0] j_prev;
  logic       unused_pix_msb;

  // OLED column -> framebuffer pixel column (each pixel spans 2^SCALE_SHIFT OLED columns)
  assign pix_c_full     = rd_col_q >> SCALE_SHIFT;
  assign pix_c          = pix_c_full[5:0];
  assign unused_pix_msb = pix_c_full[6];
  assign pix            = ram_rdata[3'd7 - pix_c[2:0]];
  assign sel_row        = pend_q ? rd_row_q : row_idx;
  assign j_prev         = cnt_q[1:0] - 2'd1;

  fb_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    acc_d      = acc_q;
    addr0_d    = addr0_q;
    mask0_d    = mask0_q;
    mask1_d    = mask1_q;
    two_d      = two_q;
    coll_acc_d = coll_acc_q;
    data_d     = data_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    coll_d     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = 8'h00;
    ram_wdata  = 8'h00;

    if (read && !pend_q) begin
      pend_d   = 1'b1;
      rd_row_d = row_idx;
      rd_col_d = column_idx;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q || read) begin
          pend_d = 1'b0;
          acc_d  = 8'h00;
          cnt_d  = 8'h00;
          if (sel_row >= 6'(OLED_PAGES)) begin
            data_d  = 8'h00;
            ack_d   = 1'b1;
            state_d = ST_RD_ACK;
          end else begin
            state_d = ST_RD_FETCH;
          end
        end else if (draw_clear) begin
          cnt_d   = 8'h00;
          state_d = ST_CLR;
        end else if (draw_req) begin
          addr0_d            = {draw_y, draw_x[5:3]};
          {mask0_d, mask1_d} = {draw_byte, 8'h00} >> draw_x[2:0];
          // Spill into the next byte only when it exists; past column 63 is clipped
          two_d              = (draw_x[2:0] != 3'd0) && (draw_x[5:3] != 3'd7);
          coll_acc_d         = 1'b0;
          state_d            = ST_DW_RD0;
        end
      end
      ST_RD_FETCH: begin
        ram_addr = {rd_row_q[2:0], cnt_q[1:0], pix_c[5:3]};
        if (cnt_q[1:0] != 2'd0) begin
          acc_d[{j_prev, 1'b0} +: 2] = {2{pix}};
        end
        cnt_d = cnt_q + 8'd1;
        if (cnt_q[1:0] == 2'd3) begin
          state_d = ST_RD_LAST;
        end
      end
      ST_RD_LAST: begin
        data_d  = acc_q | {{2{pix}}, 6'b000000};
        ack_d   = 1'b1;
        state_d = ST_RD_ACK;
      end
      ST_RD_ACK: state_d = ST_IDLE;
      ST_DW_RD0: begin
        ram_addr = addr0_q;
        state_d  = ST_DW_WR0;
      end
      ST_DW_WR0: begin
        ram_addr   = addr0_q;
        ram_we     = 1'b1;
        ram_wdata  = ram_rdata ^ mask0_q;
        coll_acc_d = |(ram_rdata & mask0_q);
        if (two_q) begin
          state_d = ST_DW_RD1;
        end else begin
          done_d  = 1'b1;
          coll_d  = coll_acc_d;
          state_d = ST_DONE;
        end
      end
      ST_DW_RD1: begin
        ram_addr = addr0_q + 8'd1;
        state_d  = ST_DW_WR1;
      end
      ST_DW_WR1: begin
        ram_addr   = addr0_q + 8'd1;
        ram_we     = 1'b1;
        ram_wdata  = ram_rdata ^ mask1_q;
        coll_acc_d = coll_acc_q | (|(ram_rdata & mask1_q));
        done_d     = 1'b1;
        coll_d     = coll_acc_d;
        state_d    = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_CLR: begin
        ram_addr = cnt_q;
        ram_we   = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == 8'(FB_BYTES - 1)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'h00;
      pend_q     <= 1'b0;
      rd_row_q   <= 6'h00;
      rd_col_q   <= 7'h00;
      acc_q      <= 8'h00;
      addr0_q    <= 8'h00;
      mask0_q    <= 8'h00;
      mask1_q    <= 8'h00;
      two_q      <= 1'b0;
      coll_acc_q <= 1'b0;
      data_q     <= 8'h00;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      acc_q      <= acc_d;
      addr0_q    <= addr0_d;
      mask0_q    <= mask0_d;
      mask1_q    <= mask1_d;
      two_q      <= two_d;
      coll_acc_q <= coll_acc_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      coll_q     <= coll_d;
    end
  end

  assign data      = data_q;
  assign ack       = ack_q;
  assign draw_done = done_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_framebuffer.sv
// tb/tb_framebuffer.sv - scoreboard bench for framebuffer: directed draws/clears/reads
module tb_framebuffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       read;
  logic [5:0] row_idx;
  logic [6:0] column_idx;
  logic [7:0] data;
  logic       ack;
  logic       draw_req;
  logic       draw_clear;
  logic [5:0] draw_x;
  logic [4:0] draw_y;
  logic [7:0] draw_byte;
  logic       draw_done;
  logic       collision;

  typedef struct {
    logic       is_rd;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  framebuffer #(.SCALE_SHIFT(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .read       (read),
    .row_idx    (row_idx),
    .column_idx (column_idx),
    .data       (data),
    .ack        (ack),
    .draw_req   (draw_req),
    .draw_clear (draw_clear),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_byte  (draw_byte),
    .draw_done  (draw_done),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_rd, input logic [7:0] val);
    exp_t e;
    e.is_rd = is_rd;
    e.val   = val;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the next expected event whenever the DUT pulses ack or draw_done
  always @(negedge clk) begin
    if (resetn && (ack || draw_done)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: ack=%0b draw_done=%0b with empty scoreboard", ack, draw_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_is_read", {31'd0, ack}, {31'd0, e.is_rd});
        if (ack) check("read_data", {24'd0, data}, {24'd0, e.val});
        else     check("collision", {31'd0, collision}, {31'd0, e.val[0]});
      end
    end
  end

  task automatic do_read(input logic [5:0] p, input logic [6:0] c, input logic [7:0] exp,
                         input int exp_lat);
    int lat;
    lat = -1;
    push(1'b1, exp);
    row_idx    = p;
    column_idx = c;
    read       = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) read = 1'b0;
      if (ack) begin
        lat = n;
        break;
      end
    end
    check("read_latency", lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic clr, input logic [5:0] x, input logic [4:0] y,
                       input logic [7:0] b, input logic exp_coll, input int bound);
    int seen;
    seen = 0;
    push(1'b0, {7'd0, exp_coll});
    draw_x     = x;
    draw_y     = y;
    draw_byte  = b;
    draw_clear = clr;
    draw_req   = ~clr;
    for (int n = 1; n <= bound; n++) begin
      @(posedge clk); #1;
      if (draw_done) begin
        seen = 1;
        break;
      end
    end
    check("draw_done_within_bound", seen, 1);
    draw_req   = 1'b0;
    draw_clear = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done_bounded(input int bound);
    int seen;
    seen = 0;
    for (int n = 1; n <= bound; n++) begin
      @(posedge clk); #1;
      if (draw_done) begin
        seen = 1;
        break;
      end
    end
    check("draw_done_seen", seen, 1);
    draw_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    resetn     = 1'b0;
    read       = 1'b0;
    row_idx    = 6'd0;
    column_idx = 7'd0;
    draw_req   = 1'b0;
    draw_clear = 1'b0;
    draw_x     = 6'd0;
    draw_y     = 5'd0;
    draw_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 0);
    check("reset_ack", ack, 0);
    check("reset_draw_done", draw_done, 0);
    check("reset_collision", collision, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 6'd0, 5'd0, 8'h00, 1'b0, 300);
    wait_drain();
    do_read(6'd0, 7'd0, 8'h00, 6);

    do_op(1'b0, 6'd0, 5'd0, 8'hF0, 1'b0, 9);
    do_read(6'd0, 7'd0, 8'h03, 6);
    do_read(6'd0, 7'd7, 8'h03, 6);
    do_read(6'd0, 7'd8, 8'h00, 6);

    do_op(1'b0, 6'd0, 5'd0, 8'hF0, 1'b1, 9);
    do_read(6'd0, 7'd0, 8'h00, 6);

    do_op(1'b0, 6'd60, 5'd5, 8'hFF, 1'b0, 9);
    do_read(6'd1, 7'd120, 8'h0C, 6);
    do_read(6'd1, 7'd127, 8'h0C, 6);
    do_read(6'd1, 7'd0, 8'h00, 6);

    // Read and draw in the same cycle: read is served first, on pre-draw contents
    push(1'b1, 8'h00);
    push(1'b0, 8'h00);
    row_idx    = 6'd0;
    column_idx = 7'd16;
    read       = 1'b1;
    draw_x     = 6'd8;
    draw_y     = 5'd0;
    draw_byte  = 8'h81;
    draw_req   = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    wait_done_bounded(30);
    @(posedge clk); #1;
    wait_drain();
    do_read(6'd0, 7'd16, 8'h03, 6);

    // Read pulse during a two-byte draw: served after draw_done, sees new pixels
    push(1'b0, 8'h00);
    push(1'b1, 8'h33);
    draw_x    = 6'd13;
    draw_y    = 5'd2;
    draw_byte = 8'hFF;
    draw_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    row_idx    = 6'd0;
    column_idx = 7'd30;
    read       = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    wait_done_bounded(20);
    @(posedge clk); #1;
    wait_drain();
    @(posedge clk); #1;

    do_read(6'd0, 7'd42, 8'h00, 6);
    do_read(6'd0, 7'd40, 8'h30, 6);
    do_read(6'd8, 7'd0, 8'h00, 1);

    // Reset while in DW_WR0
    do_read(6'd0, 7'd40, 8'h30, 6);
    draw_x    = 6'd0;
    draw_y    = 5'd31;
    draw_byte = 8'h80;
    draw_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn   = 1'b0;
    draw_req = 1'b0;
    @(posedge clk); #1;
    check("midreset_data", data, 0);
    check("midreset_ack", ack, 0);
    check("midreset_draw_done", draw_done, 0);
    check("midreset_collision", collision, 0);
    resetn = 1'b1;
    do_read(6'd0, 7'd16, 8'h03, 6);

    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    check("no_leftover_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
